// File: rtl/mgia_video_fetcher.sv
// mgia_video_fetcher: bursts one scan line per fetch window from VRAM (Wishbone classic) into the line buffer.
// Optional MGIA_FETCH_UNDERRUN_EN adds UNDERRUN_O pulse and saturating UNDERRUN_CNT_O.
module mgia_video_fetcher #(
    parameter int DATA_W         = 16,
    parameter int ADR_W          = 13,
    parameter int WORDS_PER_LINE = 40,
    parameter int LB_ADR_W       = 6
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                VSYNC_I,
    input  logic                VFEN_I,
    input  logic [ADR_W-1:0]    BASE_I,
    input  logic [ADR_W-1:0]    STRIDE_I,
    input  logic                DSCAN_I,
    output logic [ADR_W-1:0]    RAM_ADR_O,
    output logic                RAM_CYC_O,
    output logic                RAM_STB_O,
    input  logic                RAM_ACK_I,
    input  logic [DATA_W-1:0]   RAM_DAT_I,
    output logic [LB_ADR_W-1:0] LB_ADR_O,
    output logic [DATA_W-1:0]   LB_DAT_O,
    output logic                LB_WE_O,
`ifdef MGIA_FETCH_UNDERRUN_EN
    output logic                UNDERRUN_O,
    output logic [7:0]          UNDERRUN_CNT_O,
`endif
    output logic                BUSY_O
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    localparam logic [LB_ADR_W:0] LAST = (LB_ADR_W + 1)'(WORDS_PER_LINE - 1);
    state_t state;
    logic vfen_q, phase, cyc, rise, ack;
    logic [ADR_W-1:0] line_ptr;
    logic [LB_ADR_W:0] ctr;
    assign rise = VFEN_I & ~vfen_q;
    assign ack = RAM_ACK_I & cyc;
    assign RAM_CYC_O = cyc;
    assign RAM_STB_O = cyc;
    assign BUSY_O = state == FETCH;
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
            vfen_q <= 1'b0;
            phase <= 1'b0;
            cyc <= 1'b0;
            line_ptr <= '0;
            ctr <= '0;
            RAM_ADR_O <= '0;
            LB_ADR_O <= '0;
            LB_DAT_O <= '0;
            LB_WE_O <= 1'b0;
        end else begin
            vfen_q <= VFEN_I;
            LB_WE_O <= 1'b0;
            if (!VSYNC_I) begin
                line_ptr <= BASE_I;
                phase <= 1'b0;
                cyc <= 1'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state <= FETCH;
                        cyc <= 1'b1;
                        RAM_ADR_O <= line_ptr;
                        ctr <= '0;
                    end
                    // a falling fetch window aborts; an ACK in that same cycle is dropped
                    FETCH: if (!VFEN_I) begin
                        cyc <= 1'b0;
                        state <= IDLE;
                    end else if (ack) begin
                        RAM_ADR_O <= RAM_ADR_O + ADR_W'(1);
                        LB_DAT_O <= RAM_DAT_I;
                        LB_ADR_O <= ctr[LB_ADR_W-1:0];
                        LB_WE_O <= 1'b1;
                        ctr <= ctr + (LB_ADR_W + 1)'(1);
                        if (ctr == LAST) begin
                            cyc <= 1'b0;
                            state <= DONE;
                            phase <= ~phase;
                            line_ptr <= (!DSCAN_I || phase) ? line_ptr + STRIDE_I : line_ptr;
                        end
                    end
                    default: if (!VFEN_I) state <= IDLE;
                endcase
            end
        end
    end
`ifdef MGIA_FETCH_UNDERRUN_EN
    logic underrun;
    assign underrun = VSYNC_I & (state == FETCH) & ~VFEN_I;
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            UNDERRUN_O <= 1'b0;
            UNDERRUN_CNT_O <= '0;
        end else begin
            UNDERRUN_O <= underrun;
            UNDERRUN_CNT_O <= !VSYNC_I ? 8'd0 : (underrun && UNDERRUN_CNT_O != 8'hFF) ? UNDERRUN_CNT_O + 8'd1 : UNDERRUN_CNT_O;
        end
    end
`endif
endmodule
